// File: rtl/adc_sample_sched_pkg.sv
// Shared types and helpers for the ADC sample scheduler.
package adc_sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2
    } sched_state_t;

    localparam logic [15:0] OVR_CNT_MAX = 16'hFFFF;

    // Channel index width; a single-channel build still needs a 1-bit index.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sched_next_ch.sv
// Finds the lowest set mask bit strictly above idx, or the lowest set bit overall
// when from_lowest is high (idx treated as -1). none flags an empty result.
module adc_sched_next_ch
    import adc_sample_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_BITS = ch_bits(N_CH)
) (
    input  logic [N_CH-1:0]    mask,
    input  logic [CH_BITS-1:0] idx,
    input  logic               from_lowest,
    output logic [CH_BITS-1:0] next_idx,
    output logic               none
);

    // Scan high to low so the last hit written is the lowest qualifying bit.
    always_comb begin
        next_idx = '0;
        none     = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k] && (from_lowest || (k > int'(idx)))) begin
                next_idx = CH_BITS'(k);
                none     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// adc_sample_sched: on each period tick snapshots time and all channels, then
// serialises enabled channels over valid/ready. Define ADC_SAMPLE_SCHED_OVERRUN_CNT_EN
// to add the saturating overrun_cnt output.
module adc_sample_sched
    import adc_sample_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SIG_BITS    = 16,
    parameter int TIME_BITS   = 32,
    parameter int PERIOD_BITS = 16,
    parameter int CNT_BITS    = 16,
    localparam int CH_BITS    = ch_bits(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIME_BITS-1:0]       time_curr,
    input  logic [N_CH*SIG_BITS-1:0]   sig_in,
    input  logic [N_CH-1:0]            ch_mask,
    input  logic [PERIOD_BITS-1:0]     cfg_period,
    input  logic [CNT_BITS-1:0]        cfg_n_samples,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TIME_BITS-1:0]       out_time,
    output logic signed [SIG_BITS-1:0] out_sig,
    output logic [CH_BITS-1:0]         out_ch
`ifdef ADC_SAMPLE_SCHED_OVERRUN_CNT_EN
    ,
    output logic [15:0]                overrun_cnt
`endif
);

    sched_state_t state_q, state_d;

    logic [N_CH-1:0]                 mask_q;
    logic [PERIOD_BITS-1:0]          period_q;
    logic [CNT_BITS-1:0]             n_q;
    logic [PERIOD_BITS-1:0]          period_cnt;
    logic [CNT_BITS-1:0]             samp_cnt;
    logic [CNT_BITS-1:0]             samp_inc;
    logic [TIME_BITS-1:0]            snap_time;
    logic [N_CH-1:0][SIG_BITS-1:0]   snap_sig;
    logic [CH_BITS-1:0]              cur_ch;

    logic [CH_BITS-1:0] first_ch, next_ch;
    logic               first_none, next_none;

    logic tick, cfg_ok;
    logic start_run, zero_done, capture, adv, sample_end, run_end, drop;

    adc_sched_next_ch #(.N_CH(N_CH), .CH_BITS(CH_BITS)) u_first (
        .mask        (mask_q),
        .idx         ('0),
        .from_lowest (1'b1),
        .next_idx    (first_ch),
        .none        (first_none)
    );

    adc_sched_next_ch #(.N_CH(N_CH), .CH_BITS(CH_BITS)) u_next (
        .mask        (mask_q),
        .idx         (cur_ch),
        .from_lowest (1'b0),
        .next_idx    (next_ch),
        .none        (next_none)
    );

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_time  = snap_time;
    assign out_sig   = snap_sig[cur_ch];
    assign out_ch    = cur_ch;

    assign tick     = busy && (period_cnt == '0);
    assign cfg_ok   = (ch_mask != '0) && (cfg_period != '0) && (cfg_n_samples != '0);
    assign samp_inc = samp_cnt + CNT_BITS'(1);

    always_comb begin
        state_d    = state_q;
        start_run  = 1'b0;
        zero_done  = 1'b0;
        capture    = 1'b0;
        adv        = 1'b0;
        sample_end = 1'b0;
        run_end    = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        start_run = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick && !first_none) begin
                    capture = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Any tick while a snapshot is still draining is lost.
                    drop = tick;
                    if (out_ready) begin
                        if (next_none) begin
                            sample_end = 1'b1;
                            if (samp_inc == n_q) begin
                                run_end = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = WAIT;
                            end
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done       <= 1'b0;
            overrun    <= 1'b0;
            mask_q     <= '0;
            period_q   <= '0;
            n_q        <= '0;
            period_cnt <= '0;
            samp_cnt   <= '0;
            snap_time  <= '0;
            snap_sig   <= '0;
            cur_ch     <= '0;
        end else begin
            state_q <= state_d;
            done    <= zero_done | run_end;
            if (start_run) begin
                mask_q     <= ch_mask;
                period_q   <= cfg_period;
                n_q        <= cfg_n_samples;
                overrun    <= 1'b0;
                period_cnt <= cfg_period - PERIOD_BITS'(1);
                samp_cnt   <= '0;
            end else if (busy) begin
                period_cnt <= tick ? (period_q - PERIOD_BITS'(1))
                                   : (period_cnt - PERIOD_BITS'(1));
            end
            if (capture) begin
                snap_time <= time_curr;
                snap_sig  <= sig_in;
                cur_ch    <= first_ch;
            end
            if (adv)
                cur_ch <= next_ch;
            if (sample_end)
                samp_cnt <= samp_inc;
            if (drop)
                overrun <= 1'b1;
        end
    end

`ifdef ADC_SAMPLE_SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            overrun_cnt <= '0;
        else if (start_run)
            overrun_cnt <= '0;
        else if (drop && (overrun_cnt != OVR_CNT_MAX))
            overrun_cnt <= overrun_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/adc_sample_sched.md
Name: adc_sample_sched

Overview:
- Schedules periodic sampling of up to N_CH emulated ADC channels on a shared timebase.
- On each period tick it snapshots the time and all channel values, then serialises the enabled channels to one downstream logger port.
- The downstream port uses a valid/ready handshake.
- Sits between the channel datapaths (`time_curr`, per-channel `sig`) and the sample logger/host readback path.

Parameters:
- N_CH, 4, number of channel inputs.
- SIG_BITS, 16, signed sample width per channel.
- TIME_BITS, 32, timestamp width.
- PERIOD_BITS, 16, sample-period counter width in clk cycles.
- CNT_BITS, 16, width of sample-count config and counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- time_curr  in  TIME_BITS  current emulation time.
- sig_in  in  N_CH*SIG_BITS  packed signed channel values; channel k occupies bits [k*SIG_BITS +: SIG_BITS].
- ch_mask  in  N_CH  enabled channels; latched at start.
- cfg_period  in  PERIOD_BITS  cycles between ticks; latched at start.
- cfg_n_samples  in  CNT_BITS  number of ticks to capture; latched at start.
- start  in  1  single-cycle request to begin a run.
- abort  in  1  terminate the run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- overrun  out  1  sticky flag: a tick was dropped.
- out_valid  out  1  sample word valid.
- out_ready  in  1  downstream accepts.
- out_time  out  TIME_BITS  snapshot timestamp.
- out_sig  out  SIG_BITS  signed sample.
- out_ch  out  $clog2(N_CH)  channel index.

Behaviour:
- Reset values: busy=0, done=0, overrun=0, out_valid=0, out_time=0, out_sig=0, out_ch=0; FSM in IDLE.
- rst has priority over all other inputs.
- FSM states are IDLE, WAIT and SCAN.
- IDLE:
  - start with ch_mask!=0, cfg_period!=0 and cfg_n_samples!=0 → latch config, clear overrun, set period_cnt=cfg_period-1, set samp_cnt=0, go to WAIT; busy=1 from the next cycle.
  - start with any of those three config values zero → done pulses the next cycle, FSM stays in IDLE, overrun unchanged.
- Period counter: free-runs while busy. tick = (period_cnt==0); on tick it reloads cfg_period-1, otherwise it decrements.
  - cfg_period=1 gives a tick every cycle.
- WAIT on tick:
  - Register time_curr and all of sig_in into snapshot registers.
  - Set out_ch to the lowest set bit of the mask.
  - Go to SCAN.
  - out_valid=1 in the cycle after the tick, so latency is 1.
- SCAN:
  - out_time/out_sig/out_ch are driven from the snapshot.
  - out_valid, once high, holds with stable data until out_valid&&out_ready.
  - On each handshake, advance to the next higher set bit of the mask.
  - After the handshake on the highest set bit: samp_cnt+1. If it equals cfg_n_samples → out_valid=0, done pulse, go to IDLE. Otherwise → WAIT.
  - out_valid may drop for one cycle between samples.
- Tick during SCAN, or tick in the same cycle as the last handshake of a sample: the tick is dropped, overrun is set, samp_cnt is not incremented for it, and the snapshot is not disturbed.
  - The next tick is captured normally.
- Channel order is ascending index. Masked-out channels are never emitted.
- abort, in any non-IDLE state: IDLE on the next cycle, out_valid=0, busy=0, no done pulse, overrun retained.
- abort has priority over a simultaneous handshake; that handshake is still counted as transferred downstream.
- start while busy is ignored.
- start and abort in the same cycle while in IDLE: abort wins, no run begins.
- samp_cnt compare uses the full CNT_BITS width; no wrap is possible because the run terminates at equality.

Optional Feature:
- Macro: ADC_SAMPLE_SCHED_OVERRUN_CNT_EN.
- With the macro defined:
  - Adds output port overrun_cnt [15:0], reset to 0 and cleared at run start.
  - It increments on each dropped tick and saturates at 16'hFFFF.
  - The sticky overrun output still exists.
- Without the macro: the port and counter are absent; only the sticky overrun flag is present.

Decomposition:
- Package adc_sample_sched_pkg:
  - State enum (IDLE, WAIT, SCAN).
  - Function computing CH_BITS=$clog2(N_CH), with a minimum of 1.
  - Saturation constant OVR_CNT_MAX.
- Sub-module adc_sched_next_ch: combinational search for the next set mask bit strictly above a given index, plus a "none" flag. It is also used with index -1 (lowest-set-bit mode) for the first channel.

Test Plan:
- N_CH=4, mask=4'b1011, period=5, n=2, out_ready=1 → ticks 5 cycles apart; words emitted for ch 0,1,3 twice; both timestamps differ by 5; done pulses once; overrun=0.
- Same config, out_ready held low for 10 cycles after the first valid → data stable while stalled; the second tick is dropped; overrun=1; the run still completes 2 full samples.
- period=1, mask=4'b0001, n=3, out_ready=1 → tick every cycle; exactly 3 words for ch 0, taking every other tick; overrun=1.
- start with mask=0 → done pulses one cycle later; busy never rises; no out_valid.
- abort asserted 2 cycles into SCAN → out_valid=0 and busy=0 next cycle; no done; a following start runs normally.
- With ADC_SAMPLE_SCHED_OVERRUN_CNT_EN, force 3 dropped ticks → overrun_cnt=3; cleared to 0 at the next start.
